conv_col_sequencer: RTL and testbench

Sequencing controller for the 3×3 column-shift convolution engine. It loads the three kernel columns, then streams image columns strip by strip from a column memory with 1-cycle read latency. It drives the engine's `valid` and kernel/image select, and inserts one zero flush column per strip. It flags exactly the cycles in which the engine's output register holds a valid result, and tags each result with its strip and column.

---
 rtl/conv_col_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_conv_col_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/conv_col_sequencer.sv
// Sequencer for the 3x3 column-shift convolution engine: kernel load, strip streaming
// with one zero flush column per strip, and result tagging.
module conv_col_sequencer #(
  parameter int unsigned COL_ADDR_LEN = 10,
  parameter int unsigned STRIP_LEN    = 8
) (
  input  logic                    CLK100MHZ,
  input  logic                    i_reset,
  input  logic                    i_load_kernel,
  input  logic                    i_start,
  input  logic [COL_ADDR_LEN-1:0] i_num_cols,
  input  logic [STRIP_LEN-1:0]    i_num_strips,
  input  logic                    i_hold,
  output logic                    o_mem_rd,
  output logic                    o_kernel_sel,
  output logic [COL_ADDR_LEN-1:0] o_col_addr,
  output logic [STRIP_LEN-1:0]    o_strip_addr,
  output logic                    o_conv_valid,
  output logic                    o_selecK_I,
  output logic                    o_zero_data,
  output logic                    o_out_valid,
  output logic [COL_ADDR_LEN-1:0] o_out_col,
  output logic [STRIP_LEN-1:0]    o_out_strip,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err
);

  typedef enum logic [1:0] {StIdle, StKernel, StStream, StDrain} state_e;

  localparam logic [COL_ADDR_LEN-1:0] ColThree = COL_ADDR_LEN'(3);

  state_e state_q, state_d;
  logic [COL_ADDR_LEN-1:0] num_cols_q, num_cols_d, col_cnt_q, col_cnt_d;
  logic [STRIP_LEN-1:0]    num_strips_q, num_strips_d, strip_cnt_q, strip_cnt_d;
  logic [1:0]              kcnt_q, kcnt_d;
  // Slot stage (read issue) plus side-band needed to form the push one cycle later
  logic                    mem_rd_q, mem_rd_d, kernel_sel_q, kernel_sel_d;
  logic [COL_ADDR_LEN-1:0] col_addr_q, col_addr_d, slot_k_q, slot_k_d;
  logic [STRIP_LEN-1:0]    strip_addr_q, strip_addr_d, slot_strip_q, slot_strip_d;
  logic                    slot_vld_q, slot_vld_d, slot_flush_q, slot_flush_d;
  logic                    slot_kernel_q, slot_kernel_d;
  // Push stage
  logic                    conv_valid_q, conv_valid_d, selk_q, selk_d, zero_q, zero_d;
  logic [COL_ADDR_LEN-1:0] push_k_q, push_k_d;
  logic [STRIP_LEN-1:0]    push_strip_q, push_strip_d;
  // Result stage
  logic                    out_valid_q, out_valid_d;
  logic [COL_ADDR_LEN-1:0] out_col_q, out_col_d;
  logic [STRIP_LEN-1:0]    out_strip_q, out_strip_d;
  logic                    busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic                    issue, iss_flush, iss_kernel;
  logic [COL_ADDR_LEN-1:0] iss_col;
  logic [STRIP_LEN-1:0]    iss_strip;

  // Next-state: FSM, slot issue, and the slot -> push -> result pipeline
  always_comb begin
    state_d      = state_q;
    num_cols_d   = num_cols_q;
    num_strips_d = num_strips_q;
    col_cnt_d    = col_cnt_q;
    strip_cnt_d  = strip_cnt_q;
    kcnt_d       = kcnt_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    issue        = 1'b0;
    iss_flush    = 1'b0;
    iss_kernel   = 1'b0;
    iss_col      = '0;
    iss_strip    = '0;

    unique case (state_q)
      StIdle: begin
        // Busy gating keeps the idle cycle right after a finished job non-accepting
        if (!busy_q) begin
          if (i_load_kernel) begin
            state_d = StKernel;
            kcnt_d  = 2'd0;
          end else if (i_start) begin
            if (i_num_cols >= ColThree && i_num_strips != '0) begin
              num_cols_d   = i_num_cols;
              num_strips_d = i_num_strips;
              col_cnt_d    = '0;
              strip_cnt_d  = '0;
              state_d      = StStream;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      StKernel: begin
        // Stay until the third push is being registered so busy covers it
        if (kcnt_q == 2'd3) begin
          state_d = StIdle;
        end else if (!i_hold) begin
          issue      = 1'b1;
          iss_kernel = 1'b1;
          iss_col    = COL_ADDR_LEN'(kcnt_q);
          kcnt_d     = kcnt_q + 2'd1;
        end
      end
      StStream: begin
        if (!i_hold) begin
          issue     = 1'b1;
          iss_col   = col_cnt_q;
          iss_strip = strip_cnt_q;
          if (col_cnt_q == num_cols_q) begin
            iss_flush = 1'b1;
            if (strip_cnt_q == num_strips_q - STRIP_LEN'(1)) begin
              state_d = StDrain;
            end else begin
              col_cnt_d   = '0;
              strip_cnt_d = strip_cnt_q + STRIP_LEN'(1);
            end
          end else begin
            col_cnt_d = col_cnt_q + COL_ADDR_LEN'(1);
          end
        end
      end
      StDrain: begin
        // Final result is the one with no push behind it
        if (out_valid_q && !conv_valid_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    mem_rd_d      = issue && !iss_flush;
    kernel_sel_d  = issue && iss_kernel;
    col_addr_d    = (issue && !iss_flush) ? iss_col : '0;
    strip_addr_d  = (issue && !iss_flush) ? iss_strip : '0;
    slot_vld_d    = issue;
    slot_flush_d  = issue && iss_flush;
    slot_kernel_d = issue && iss_kernel;
    slot_k_d      = issue ? iss_col : '0;
    slot_strip_d  = issue ? iss_strip : '0;

    conv_valid_d  = slot_vld_q;
    selk_d        = slot_vld_q && !slot_kernel_q;
    zero_d        = slot_vld_q && slot_flush_q;
    push_k_d      = slot_vld_q ? slot_k_q : '0;
    push_strip_d  = slot_vld_q ? slot_strip_q : '0;

    // Pushes 0..2 of a strip only refill the window, so they report nothing
    out_valid_d   = selk_q && (push_k_q >= ColThree);
    out_col_d     = out_valid_d ? (push_k_q - ColThree) : '0;
    out_strip_d   = out_valid_d ? push_strip_q : '0;

    busy_d        = (state_q != StIdle);
  end

  // State and registered outputs, synchronous reset cancels anything in flight
  always_ff @(posedge CLK100MHZ) begin
    if (i_reset) begin
      state_q      <= StIdle;
      num_cols_q   <= '0;
      num_strips_q <= '0;
      col_cnt_q    <= '0;
      strip_cnt_q  <= '0;
      kcnt_q       <= 2'd0;
      mem_rd_q     <= 1'b0;
      kernel_sel_q <= 1'b0;
      col_addr_q   <= '0;
      strip_addr_q <= '0;
      slot_vld_q   <= 1'b0;
      slot_flush_q <= 1'b0;
      slot_kernel_q <= 1'b0;
      slot_k_q     <= '0;
      slot_strip_q <= '0;
      conv_valid_q <= 1'b0;
      selk_q       <= 1'b0;
      zero_q       <= 1'b0;
      push_k_q     <= '0;
      push_strip_q <= '0;
      out_valid_q  <= 1'b0;
      out_col_q    <= '0;
      out_strip_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_cols_q   <= num_cols_d;
      num_strips_q <= num_strips_d;
      col_cnt_q    <= col_cnt_d;
      strip_cnt_q  <= strip_cnt_d;
      kcnt_q       <= kcnt_d;
      mem_rd_q     <= mem_rd_d;
      kernel_sel_q <= kernel_sel_d;
      col_addr_q   <= col_addr_d;
      strip_addr_q <= strip_addr_d;
      slot_vld_q   <= slot_vld_d;
      slot_flush_q <= slot_flush_d;
      slot_kernel_q <= slot_kernel_d;
      slot_k_q     <= slot_k_d;
      slot_strip_q <= slot_strip_d;
      conv_valid_q <= conv_valid_d;
      selk_q       <= selk_d;
      zero_q       <= zero_d;
      push_k_q     <= push_k_d;
      push_strip_q <= push_strip_d;
      out_valid_q  <= out_valid_d;
      out_col_q    <= out_col_d;
      out_strip_q  <= out_strip_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign o_mem_rd     = mem_rd_q;
  assign o_kernel_sel = kernel_sel_q;
  assign o_col_addr   = col_addr_q;
  assign o_strip_addr = strip_addr_q;
  assign o_conv_valid = conv_valid_q;
  assign o_selecK_I   = selk_q;
  assign o_zero_data  = zero_q;
  assign o_out_valid  = out_valid_q;
  assign o_out_col    = out_col_q;
  assign o_out_strip  = out_strip_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_conv_col_sequencer.sv
// Directed bench for conv_col_sequencer: every output is compared each cycle against
// hand-derived timelines (cycle 0 = edge that samples the start/load pulse).
module tb_conv_col_sequencer;
  localparam int CW = 10;
  localparam int SW = 8;
  localparam int NC = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_reset, i_load_kernel, i_start, i_hold;
  logic [CW-1:0] i_num_cols;
  logic [SW-1:0] i_num_strips;
  logic          o_mem_rd, o_kernel_sel, o_conv_valid, o_selecK_I, o_zero_data;
  logic          o_out_valid, o_busy, o_done, o_err;
  logic [CW-1:0] o_col_addr, o_out_col;
  logic [SW-1:0] o_strip_addr, o_out_strip;

  conv_col_sequencer #(.COL_ADDR_LEN(CW), .STRIP_LEN(SW)) dut (
    .CLK100MHZ    (clk),
    .i_reset      (i_reset),
    .i_load_kernel(i_load_kernel),
    .i_start      (i_start),
    .i_num_cols   (i_num_cols),
    .i_num_strips (i_num_strips),
    .i_hold       (i_hold),
    .o_mem_rd     (o_mem_rd),
    .o_kernel_sel (o_kernel_sel),
    .o_col_addr   (o_col_addr),
    .o_strip_addr (o_strip_addr),
    .o_conv_valid (o_conv_valid),
    .o_selecK_I   (o_selecK_I),
    .o_zero_data  (o_zero_data),
    .o_out_valid  (o_out_valid),
    .o_out_col    (o_out_col),
    .o_out_strip  (o_out_strip),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;

  // Expected timeline, one entry per cycle
  logic          e_rd[NC], e_ks[NC], e_cv[NC], e_sel[NC], e_z[NC], e_ov[NC];
  logic          e_busy[NC], e_done[NC], e_err[NC];
  logic [CW-1:0] e_ca[NC], e_oc[NC];
  logic [SW-1:0] e_sa[NC], e_os[NC];

  function automatic logic [44:0] obs();
    return {o_mem_rd, o_kernel_sel, o_col_addr, o_strip_addr, o_conv_valid, o_selecK_I,
            o_zero_data, o_out_valid, o_out_col, o_out_strip, o_busy, o_done, o_err};
  endfunction

  function automatic logic [44:0] exp_vec(int c);
    return {e_rd[c], e_ks[c], e_ca[c], e_sa[c], e_cv[c], e_sel[c], e_z[c], e_ov[c],
            e_oc[c], e_os[c], e_busy[c], e_done[c], e_err[c]};
  endfunction

  task automatic clear_exp();
    for (int i = 0; i < NC; i++) begin
      e_rd[i] = 0; e_ks[i] = 0; e_cv[i] = 0; e_sel[i] = 0; e_z[i] = 0; e_ov[i] = 0;
      e_busy[i] = 0; e_done[i] = 0; e_err[i] = 0;
      e_ca[i] = '0; e_oc[i] = '0; e_sa[i] = '0; e_os[i] = '0;
    end
  endtask

  // Slot j lands on cycle 1+j, pushed slots after a hold of hl cycles starting at cycle 3
  task automatic build_frame(input int n, input int s, input int hl);
    int sc, col, strip, last;
    last = 0;
    for (int j = 0; j < s * (n + 1); j++) begin
      strip = j / (n + 1);
      col   = j % (n + 1);
      sc    = 1 + j + ((j >= 2) ? hl : 0);
      if (col < n) begin
        e_rd[sc] = 1; e_ca[sc] = CW'(col); e_sa[sc] = SW'(strip);
      end
      e_cv[sc+1] = 1; e_sel[sc+1] = 1; e_z[sc+1] = (col == n);
      if (col >= 3) begin
        e_ov[sc+2] = 1; e_oc[sc+2] = CW'(col - 3); e_os[sc+2] = SW'(strip);
      end
      last = sc;
    end
    e_done[last+3] = 1;
    for (int c = 1; c <= last + 3; c++) e_busy[c] = 1;
  endtask

  task automatic build_kernel();
    for (int j = 0; j < 3; j++) begin
      e_rd[1+j] = 1; e_ks[1+j] = 1; e_ca[1+j] = CW'(j);
      e_cv[2+j] = 1;
    end
    for (int c = 1; c <= 4; c++) e_busy[c] = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag);
    n_assert++;
    assert (obs() === exp_vec(cyc))
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %h required %h", tag, cyc, obs(), exp_vec(cyc));
    end
  endtask

  // Runs to last_cyc checking every cycle; optional hold window and busy-time pokes
  task automatic run_checked(input string tag, input int last_cyc, input int hl,
                             input bit poke);
    while (cyc < last_cyc) begin
      i_hold = ((cyc + 1) >= 3) && ((cyc + 1) < 3 + hl);
      if (poke && cyc == 4) begin
        i_start = 1; i_load_kernel = 1; i_num_cols = CW'(3); i_num_strips = SW'(1);
      end else if (poke && cyc == 5) begin
        i_start = 0; i_load_kernel = 0;
      end
      step();
      chk(tag);
    end
    i_hold = 0;
  endtask

  task automatic launch(input bit st, input bit ld, input int n, input int s,
                        input string tag);
    i_num_cols = CW'(n); i_num_strips = SW'(s);
    i_start = st; i_load_kernel = ld;
    cyc = -1;
    step();
    chk(tag);
    i_start = 0; i_load_kernel = 0;
  endtask

  initial begin
    i_reset = 1; i_load_kernel = 0; i_start = 0; i_hold = 0;
    i_num_cols = '0; i_num_strips = '0;
    clear_exp();
    cyc = 0;
    step(); chk("reset");
    step(); chk("reset");
    i_reset = 0;
    for (int i = 0; i < 5; i++) begin
      step(); chk("idle");
    end

    clear_exp(); build_kernel();
    launch(0, 1, 0, 0, "kernel");
    run_checked("kernel", 7, 0, 0);

    clear_exp(); build_frame(5, 2, 0);
    launch(1, 0, 5, 2, "frame");
    run_checked("frame", 18, 0, 1);

    clear_exp(); build_frame(5, 2, 2);
    launch(1, 0, 5, 2, "hold");
    run_checked("hold", 20, 2, 0);

    clear_exp(); e_err[0] = 1;
    launch(1, 0, 2, 2, "rej_n2");
    run_checked("rej_n2", 3, 0, 0);

    clear_exp(); e_err[0] = 1;
    launch(1, 0, 5, 0, "rej_s0");
    run_checked("rej_s0", 3, 0, 0);

    clear_exp(); build_kernel();
    launch(1, 1, 5, 2, "start_and_load");
    run_checked("start_and_load", 7, 0, 0);

    clear_exp(); build_frame(5, 2, 0);
    launch(1, 0, 5, 2, "pre_reset");
    run_checked("pre_reset", 6, 0, 0);
    i_reset = 1;
    clear_exp();
    step(); chk("mid_reset");
    i_reset = 0;
    run_checked("post_reset", 20, 0, 0);

    clear_exp(); build_frame(5, 2, 0);
    launch(1, 0, 5, 2, "refr");
    run_checked("refr", 18, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
